// File: rtl/detector_nota.sv
// Pitch detector for the music-box tone: measures the rising-edge period of
// tono_in in clk cycles and reports the matching key (do..si) one-hot.

module detector_nota_cmp #(
    parameter int unsigned ANCHO = 21,
    parameter int unsigned NOM   = 0,
    parameter int unsigned TOL   = 0
) (
    input  logic [ANCHO-1:0] i_per,
    output logic             o_hit
);
    logic [31:0] w_per32;

    assign w_per32 = 32'(i_per);
    // Two one-sided tests keep the unsigned window free of wrap-around.
    assign o_hit = (w_per32 + TOL >= NOM) && (w_per32 <= NOM + TOL);
endmodule

module detector_nota #(
    parameter int unsigned ANCHO   = 21,
    parameter int unsigned P_DO    = 191110,
    parameter int unsigned P_RE    = 170265,
    parameter int unsigned P_MI    = 151685,
    parameter int unsigned P_FA    = 143172,
    parameter int unsigned P_SOL   = 127551,
    parameter int unsigned P_LA    = 113636,
    parameter int unsigned P_SI    = 101238,
    parameter int unsigned TOL     = 1000,
    parameter int unsigned N_CONF  = 2,
    parameter int unsigned TIMEOUT = (2**21) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tono_in,
    output logic [6:0]       teclas,
    output logic             valida,
    output logic [ANCHO-1:0] periodo,
    output logic             nueva
);
    localparam int unsigned NC_W = $clog2(N_CONF + 1);
    localparam logic [NC_W-1:0]  NC_MAX = NC_W'(N_CONF);
    localparam logic [ANCHO-1:0] TMO    = ANCHO'(TIMEOUT);
    localparam int unsigned P_NOM [7] = '{P_DO, P_RE, P_MI, P_FA, P_SOL, P_LA, P_SI};

    typedef enum logic {ESPERA, MIDE} estado_t;

    estado_t          r_estado;
    logic [2:0]       r_sinc;
    logic [ANCHO-1:0] r_cnt;
    logic [6:0]       r_ult;
    logic [NC_W-1:0]  r_igu;
    logic [6:0]       r_teclas;
    logic             r_valida;
    logic [ANCHO-1:0] r_periodo;
    logic             r_nueva;

    logic             w_flanco;
    logic             w_sat;
    logic [ANCHO-1:0] w_per;
    logic [6:0]       w_cand;
    logic [NC_W-1:0]  w_igu_nxt;
    logic             w_conf;

    // r_sinc[0..1] is the synchronizer, r_sinc[2] the delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) r_sinc <= '0;
        else       r_sinc <= {r_sinc[1:0], tono_in};
    end

    assign w_flanco = r_sinc[1] & ~r_sinc[2];
    assign w_sat    = (r_cnt == TMO);

    always_ff @(posedge clk) begin
        if (reset)         r_cnt <= '0;
        else if (w_flanco) r_cnt <= '0;
        else if (!w_sat)   r_cnt <= r_cnt + 1'b1;
    end

    // An edge landing on the saturated count reports TIMEOUT, not TIMEOUT+1.
    assign w_per = w_sat ? TMO : r_cnt + 1'b1;

    for (genvar k = 0; k < 7; k++) begin : g_cls
        detector_nota_cmp #(
            .ANCHO (ANCHO),
            .NOM   (P_NOM[k]),
            .TOL   (TOL)
        ) u_cmp (
            .i_per (w_per),
            .o_hit (w_cand[k])
        );
    end

    always_comb begin
        w_igu_nxt = NC_W'(1);
        if (w_cand == r_ult)
            w_igu_nxt = (r_igu >= NC_MAX) ? NC_MAX : r_igu + 1'b1;
    end

    assign w_conf = (w_igu_nxt >= NC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= ESPERA;
            r_ult     <= '0;
            r_igu     <= '0;
            r_teclas  <= '0;
            r_valida  <= 1'b0;
            r_periodo <= '0;
            r_nueva   <= 1'b0;
        end else begin
            r_nueva <= 1'b0;
            case (r_estado)
                ESPERA: begin
                    if (w_flanco) r_estado <= MIDE;
                end
                MIDE: begin
                    if (w_flanco) begin
                        r_periodo <= w_per;
                        r_ult     <= w_cand;
                        r_igu     <= w_igu_nxt;
                        if (w_conf && (w_cand != r_teclas)) begin
                            r_teclas <= w_cand;
                            r_valida <= |w_cand;
                            r_nueva  <= 1'b1;
                        end
                    end else if (w_sat) begin
                        r_teclas <= '0;
                        r_valida <= 1'b0;
                        r_nueva  <= |r_teclas;
                        r_ult    <= '0;
                        r_igu    <= '0;
                        r_estado <= ESPERA;
                    end
                end
                default: r_estado <= ESPERA;
            endcase
        end
    end

    assign teclas  = r_teclas;
    assign valida  = r_valida;
    assign periodo = r_periodo;
    assign nueva   = r_nueva;
endmodule

// File: tb/tb_detector_nota.sv
// Randomized scoreboard bench for detector_nota with scaled-down periods so
// whole tone sequences, silences and resets fit in a short run.

module tb_detector_nota;
    localparam int ANCHO   = 10;
    localparam int TOL     = 4;
    localparam int N_CONF  = 2;
    localparam int TIMEOUT = 600;
    localparam int NOM [7] = '{191, 170, 152, 143, 128, 114, 101};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tono_in = 1'b0;
    logic [6:0]       teclas;
    logic             valida;
    logic [ANCHO-1:0] periodo;
    logic             nueva;

    detector_nota #(
        .ANCHO (ANCHO), .P_DO (NOM[0]), .P_RE (NOM[1]), .P_MI (NOM[2]),
        .P_FA (NOM[3]), .P_SOL (NOM[4]), .P_LA (NOM[5]), .P_SI (NOM[6]),
        .TOL (TOL), .N_CONF (N_CONF), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset (reset), .tono_in (tono_in),
        .teclas (teclas), .valida (valida), .periodo (periodo), .nueva (nueva)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] teclas; int periodo; } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_nueva_cyc = 0;
    int rise_cyc = 0;

    // Reference model state: listening flag, cycles since last rise,
    // last measured period, current key and recent classifications.
    bit         m_mide = 1'b0;
    int         m_gap = 0;
    int         m_per = 0;
    logic [6:0] m_teclas = '0;
    logic [6:0] hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every nueva pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (nueva) begin
            last_nueva_cyc = cyc;
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_nueva: got pulse with teclas=%b expected none (cycle %0d)", teclas, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("nueva_teclas", 32'(teclas), 32'(e.teclas));
                chk("nueva_valida", 32'(valida), 32'(e.teclas != 0));
                chk("nueva_periodo", 32'(periodo), 32'(e.periodo));
            end
        end
    end

    function automatic logic [6:0] classify(input int p);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < 7; k++)
            if (p >= NOM[k] - TOL && p <= NOM[k] + TOL) c[k] = 1'b1;
        return c;
    endfunction

    task automatic model_rise();
        if (!m_mide) begin
            m_mide = 1'b1;
        end else begin
            int p;
            logic [6:0] c;
            bit same;
            p = (m_gap > TIMEOUT) ? TIMEOUT : m_gap;
            m_per = p;
            c = classify(p);
            hist.push_back(c);
            if (hist.size() > N_CONF) void'(hist.pop_front());
            same = (hist.size() >= N_CONF);
            foreach (hist[j]) if (hist[j] != c) same = 1'b0;
            if (same && c != m_teclas) begin
                m_teclas = c;
                sb.push_back('{c, p});
            end
        end
        m_gap = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One tone period: rising edge now, random duty, next rise p cycles later.
    task automatic period(input int p);
        int h;
        model_rise();
        tono_in = 1'b1;
        rise_cyc = cyc;
        h = int'($urandom_range(3 * p / 4, p / 4));
        tick(h);
        tono_in = 1'b0;
        tick(p - h);
        m_gap += p;
    endtask

    task automatic silence(input int n);
        m_gap += n;
        if (m_mide && m_gap > TIMEOUT + 1) begin
            if (m_teclas != 0) sb.push_back('{7'b0, m_per});
            m_teclas = '0;
            hist.delete();
            m_mide = 1'b0;
        end
        tick(n);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_teclas = '0;
        m_per = 0;
        m_mide = 1'b0;
        hist.delete();
        @(negedge clk);
        chk({nm, "_teclas"}, 32'(teclas), 0);
        chk({nm, "_valida"}, 32'(valida), 0);
        chk({nm, "_periodo"}, 32'(periodo), 0);
        chk({nm, "_nueva"}, 32'(nueva), 0);
        tick(1);
    endtask

    task automatic tone(input int p, input int n);
        repeat (n) period(p);
    endtask

    initial begin
        #(10 * 98000);
        n_err++;
        $display("FAIL watchdog: got no completion expected finish within 98000 cycles");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        int lat;
        tick(3);
        do_reset("reset");

        tone(NOM[5], 5);                    // LA: update on 3rd edge only
        tone(NOM[0], 4);                    // switch to DO
        tone(NOM[2] + TOL, 4);              // MI at upper tolerance edge
        tone(NOM[2] + TOL + 1, 4);          // one past tolerance -> unknown
        tone(NOM[4], 4);                    // SOL then silence
        silence(TIMEOUT + 100);
        lat = last_nueva_cyc - rise_cyc;
        n_chk++;
        if (lat < TIMEOUT || lat > TIMEOUT + 8) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, TIMEOUT, TIMEOUT + 8);
        end
        period(NOM[4]);                     // single edge from ESPERA
        silence(TIMEOUT + 50);
        for (int i = 0; i < 3; i++) begin   // SI/RE alternation never confirms
            period(NOM[6]);
            period(NOM[1]);
        end
        tone(NOM[3], 4);                    // FA, reset, FA again
        do_reset("reset_mid_tone");
        tone(NOM[3], 4);
        for (int i = 0; i < 2; i++) begin   // gap of TIMEOUT+1 is a measurement
            period(NOM[3]);
            silence(TIMEOUT + 1 - NOM[3]);
        end
        tone(NOM[3], 4);
        period(NOM[3]);                     // gap of TIMEOUT+2 is a timeout
        silence(TIMEOUT + 2 - NOM[3]);
        tone(NOM[3], 3);

        for (int it = 0; it < 90; it++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 8) begin
                silence(TIMEOUT + int'($urandom_range(150, 2)));
            end else if (r < 14) begin
                do_reset("reset_rand");
            end else begin
                int k;
                int reps;
                k = int'($urandom_range(7, 0));
                reps = int'($urandom_range(4, 1));
                for (int n = 0; n < reps; n++) begin
                    int p;
                    int sel;
                    sel = int'($urandom_range(3, 0));
                    if (k == 7)        p = int'($urandom_range(250, 60));
                    else if (sel == 0) p = NOM[k];
                    else if (sel == 1) p = NOM[k] + int'($urandom_range(2 * TOL, 0)) - TOL;
                    else if (sel == 2) p = NOM[k] + (($urandom_range(1, 0) == 0) ? TOL : -TOL);
                    else               p = NOM[k] + (($urandom_range(1, 0) == 0) ? TOL + 1 : -(TOL + 1));
                    period(p);
                end
            end
        end

        silence(TIMEOUT + 50);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
